fp_div_iterative: RTL and testbench

Parametrised, multi-cycle IEEE-754-style floating-point divider (result = a / b) for the FPU datapath. It uses one radix-2 restoring quotient bit per cycle, round-to-nearest-even, and a start/busy/done handshake, so the FPU control can stall on it instead of paying a single-cycle combinational divide. Width is generic over exponent and mantissa fields; defaults give binary32. Subnormals are flushed to zero on input and output.

---
 rtl/fp_div_iterative.sv | 187 ++++++++++++++++++
 tb/tb_fp_div_iterative.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_iterative.sv
// rtl/fp_div_iterative.sv - multi-cycle radix-2 restoring floating-point divider
//
// Computes result = a / b, one quotient bit per cycle, round-to-nearest-even.
// Subnormal operands are treated as zero and subnormal results flush to zero.
//
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   start             request, accepted only in the idle state
//   a, b              dividend / divisor, captured on an accepted start
//   busy              high while the divide and round steps run
//   done              one-cycle pulse, result and flags valid
//   result            quotient, held until the next accepted start
//   divide_by_zero    finite nonzero operand divided by zero
//   invalid           NaN operand, 0/0 or inf/inf
//   overflow          finite operands, result rounded to +-inf
//   underflow         finite nonzero operands, result flushed to +-0
module fp_div_iterative #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   divide_by_zero,
    output logic                   invalid,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int BIAS = (2 ** (EXP_W - 1)) - 1;
    localparam int EW   = EXP_W + 2;
    localparam int CW   = $clog2(MAN_W + 4);
    localparam logic [EW-2:0] E_MAX = (EW-1)'((2 ** EXP_W) - 1);

    typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_ROUND, S_DONE} state_t;

    state_t             state;
    logic [W-1:0]       a_r;
    logic [W-1:0]       b_r;
    logic [MAN_W+1:0]   rem;
    logic [MAN_W+2:0]   q;
    logic [CW-1:0]      cnt;

    // Returns {hit, invalid, divide_by_zero, result} for the special-operand cases.
    function automatic logic [W+2:0] special_eval(input logic [W-1:0] x, input logic [W-1:0] y);
        logic x_max, y_max, x_nan, y_nan, x_inf, y_inf, x_zero, y_zero, s;
        logic [W-1:0] qnan, inf_v, zero_v;
        x_max  = &x[W-2:MAN_W];
        y_max  = &y[W-2:MAN_W];
        x_nan  = x_max && (|x[MAN_W-1:0]);
        y_nan  = y_max && (|y[MAN_W-1:0]);
        x_inf  = x_max && !(|x[MAN_W-1:0]);
        y_inf  = y_max && !(|y[MAN_W-1:0]);
        x_zero = ~|x[W-2:MAN_W];
        y_zero = ~|y[W-2:MAN_W];
        s      = x[W-1] ^ y[W-1];
        qnan   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        inf_v  = {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        zero_v = {s, {(W-1){1'b0}}};
        special_eval = '0;
        if (x_nan || y_nan)
            special_eval = {1'b1, 1'b1, 1'b0, qnan};
        else if ((x_zero && y_zero) || (x_inf && y_inf))
            special_eval = {1'b1, 1'b1, 1'b0, qnan};
        else if (x_inf)
            special_eval = {1'b1, 1'b0, 1'b0, inf_v};
        else if (y_zero)
            special_eval = {1'b1, 1'b0, 1'b1, inf_v};
        else if (y_inf || x_zero)
            special_eval = {1'b1, 1'b0, 1'b0, zero_v};
    endfunction

    logic [W+2:0]     spec_in;
    logic [W+2:0]     spec_hold;
    logic [MAN_W:0]   divisor;
    logic             rem_ge;
    logic [MAN_W+1:0] rem_sub;
    logic             norm;
    logic [MAN_W-1:0] frac_pre;
    logic             guard;
    logic             sticky;
    logic [MAN_W:0]   frac_sum;
    logic [EW-1:0]    exp_sum;
    logic             sign_q;

    always_comb begin
        spec_in   = special_eval(a, b);
        spec_hold = special_eval(a_r, b_r);
        divisor   = {1'b1, b_r[MAN_W-1:0]};
        rem_ge    = rem >= {1'b0, divisor};
        rem_sub   = rem_ge ? (rem - {1'b0, divisor}) : rem;
        // Quotient below 1 means one fewer integer bit: realign and drop the exponent by one.
        norm      = q[MAN_W+2];
        frac_pre  = norm ? q[MAN_W+1:2] : q[MAN_W:1];
        guard     = norm ? q[1] : q[0];
        sticky    = (norm & q[0]) | (|rem);
        frac_sum  = {1'b0, frac_pre} + {{MAN_W{1'b0}}, guard & (sticky | frac_pre[0])};
        // Two spare bits keep the biased exponent signed and free of wrap.
        exp_sum   = {2'b00, a_r[W-2:MAN_W]} - {2'b00, b_r[W-2:MAN_W]} + EW'(BIAS)
                    - {{(EW-1){1'b0}}, ~norm} + {{(EW-1){1'b0}}, frac_sum[MAN_W]};
        sign_q    = a_r[W-1] ^ b_r[W-1];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            a_r            <= '0;
            b_r            <= '0;
            rem            <= '0;
            q              <= '0;
            cnt            <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            result         <= '0;
            divide_by_zero <= 1'b0;
            invalid        <= 1'b0;
            overflow       <= 1'b0;
            underflow      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_r            <= a;
                        b_r            <= b;
                        result         <= '0;
                        divide_by_zero <= 1'b0;
                        invalid        <= 1'b0;
                        overflow       <= 1'b0;
                        underflow      <= 1'b0;
                        rem            <= {1'b0, 1'b1, a[MAN_W-1:0]};
                        q              <= '0;
                        cnt            <= CW'(MAN_W + 3);
                        if (spec_in[W+2]) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_DIVIDE;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_DIVIDE: begin
                    rem <= {rem_sub[MAN_W:0], 1'b0};
                    q   <= {q[MAN_W+1:0], rem_ge};
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1))
                        state <= S_ROUND;
                end
                S_ROUND: begin
                    busy  <= 1'b0;
                    state <= S_DONE;
                    if (!exp_sum[EW-1] && (exp_sum[EW-2:0] >= E_MAX)) begin
                        result   <= {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        overflow <= 1'b1;
                    end else if (exp_sum[EW-1] || (exp_sum == '0)) begin
                        result    <= {sign_q, {(W-1){1'b0}}};
                        underflow <= 1'b1;
                    end else begin
                        result <= {sign_q, exp_sum[EXP_W-1:0], frac_sum[MAN_W-1:0]};
                    end
                end
                S_DONE: begin
                    // First DONE cycle publishes special results and raises done;
                    // second returns to idle. start is ignored in both.
                    if (!done) begin
                        done <= 1'b1;
                        if (spec_hold[W+2]) begin
                            result         <= spec_hold[W-1:0];
                            invalid        <= spec_hold[W+1];
                            divide_by_zero <= spec_hold[W];
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_iterative.sv
// tb/tb_fp_div_iterative.sv - scoreboard bench for fp_div_iterative
module tb_fp_div_iterative;

    localparam int MAN_W = 23;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        busy, done, dbz, inv, ovf, unf;
    logic [31:0] result;

    logic        start64 = 1'b0;
    logic [63:0] a64 = '0;
    logic [63:0] b64 = '0;
    logic        busy64, done64, dbz64, inv64, ovf64, unf64;
    logic [63:0] result64;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  fl;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    fp_div_iterative #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .a(a_in), .b(b_in),
        .busy(busy), .done(done), .result(result), .divide_by_zero(dbz),
        .invalid(inv), .overflow(ovf), .underflow(unf)
    );

    fp_div_iterative #(.EXP_W(11), .MAN_W(52)) dut64 (
        .clk(clk), .reset_n(reset_n), .start(start64), .a(a64), .b(b64),
        .busy(busy64), .done(done64), .result(result64), .divide_by_zero(dbz64),
        .invalid(inv64), .overflow(ovf64), .underflow(unf64)
    );

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference: exact integer quotient with one extra bit, then RNE on the remainder.
    function automatic void ref_div(input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] r, output logic [3:0] fl, output bit spec);
        bit xn, yn, xi, yi, xz, yz, s, guard, sticky;
        longint ma, mb, num, qq, rr, m;
        int e;
        xn = (x[30:23] == 8'hFF) && (x[22:0] != 0);
        yn = (y[30:23] == 8'hFF) && (y[22:0] != 0);
        xi = (x[30:23] == 8'hFF) && (x[22:0] == 0);
        yi = (y[30:23] == 8'hFF) && (y[22:0] == 0);
        xz = (x[30:23] == 8'h00);
        yz = (y[30:23] == 8'h00);
        s  = x[31] ^ y[31];
        spec = 1'b1;
        fl = 4'b0000;
        r = '0;
        if (xn || yn) begin
            r = 32'h7FC00000; fl = 4'b0100;
        end else if ((xz && yz) || (xi && yi)) begin
            r = 32'h7FC00000; fl = 4'b0100;
        end else if (xi) begin
            r = {s, 8'hFF, 23'd0};
        end else if (yz) begin
            r = {s, 8'hFF, 23'd0}; fl = 4'b1000;
        end else if (yi || xz) begin
            r = {s, 31'd0};
        end else begin
            spec = 1'b0;
            ma = longint'({1'b1, x[22:0]});
            mb = longint'({1'b1, y[22:0]});
            e  = int'(x[30:23]) - int'(y[30:23]) + 127;
            if (ma >= mb) begin
                num = ma << 24;
            end else begin
                num = ma << 25;
                e--;
            end
            qq = num / mb;
            rr = num % mb;
            guard  = qq[0];
            sticky = (rr != 0);
            m = qq >> 1;
            if (guard && (sticky || m[0])) m++;
            if (m == (64'd1 << 24)) begin
                m = 64'd1 << 23;
                e++;
            end
            if (e >= 255) begin
                r = {s, 8'hFF, 23'd0}; fl = 4'b0010;
            end else if (e <= 0) begin
                r = {s, 31'd0}; fl = 4'b0001;
            end else begin
                r = {s, 8'(e), m[22:0]};
            end
        end
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        int c;
        v = $urandom;
        c = $urandom_range(0, 15);
        case (c)
            0:       v[30:23] = 8'h00;
            1:       begin v[30:23] = 8'hFF; v[22:0] = '0; end
            2:       begin v[30:23] = 8'hFF; v[22] = 1'b1; end
            3, 4, 5: v[30:23] = 8'($urandom_range(1, 254));
            6:       begin v[30:23] = 8'($urandom_range(100, 154)); v[22:0] = '1; end
            default: v[30:23] = 8'($urandom_range(100, 154));
        endcase
        return v;
    endfunction

    // Monitor: every done pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (reset_n && done) begin
            if (sb.size() == 0) begin
                check(1'b0, "unexpected_done", {28'd0, result, dbz, inv, ovf, unf}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({result, dbz, inv, ovf, unf} === {e.res, e.fl}, "result_flags",
                      {28'd0, result, dbz, inv, ovf, unf}, {28'd0, e.res, e.fl});
            end
        end
    end

    task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] er, input logic [3:0] efl, input bit spec,
                          input bit mid_pulse, input bit done_pulse);
        int edges, lat, busy_bad;
        bit exp_busy;
        @(negedge clk);
        a_in = x; b_in = y; start = 1'b1;
        sb.push_back('{res: er, fl: efl});
        @(posedge clk); #1;
        start = 1'b0;
        lat = spec ? 1 : MAN_W + 5;
        edges = 0;
        busy_bad = 0;
        while (!done && edges < 100) begin
            exp_busy = !spec && (edges <= MAN_W + 3);
            if (busy !== exp_busy) busy_bad++;
            if (mid_pulse && edges == 3) begin
                a_in = 32'h3F800000; b_in = 32'h40400000; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            edges++;
        end
        start = 1'b0;
        check(done && edges == lat, "latency", 64'(edges), 64'(lat));
        check(busy_bad == 0, "busy_window", 64'(busy_bad), 64'd0);
        if (!done) sb.delete();
        if (done_pulse) begin
            a_in = 32'h3F800000; b_in = 32'h40400000; start = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        check(busy === 1'b0 && done === 1'b0, "idle_after_done", {62'd0, busy, done}, 64'd0);
        check(result === er, "result_hold", 64'(result), 64'(er));
    endtask

    task automatic run_ref(input logic [31:0] x, input logic [31:0] y, input bit mid_pulse, input bit done_pulse);
        logic [31:0] r;
        logic [3:0]  fl;
        bit spec;
        ref_div(x, y, r, fl, spec);
        run_op(x, y, r, fl, spec, mid_pulse, done_pulse);
    endtask

    // Directed cases carry hand-derived expected values.
    task automatic run_dir(input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] er, input logic [3:0] efl, input bit done_pulse);
        logic [31:0] r;
        logic [3:0]  fl;
        bit spec;
        ref_div(x, y, r, fl, spec);
        run_op(x, y, er, efl, spec, 1'b0, done_pulse);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int edges;
        repeat (3) @(posedge clk);
        #1;
        check({busy, done, result, dbz, inv, ovf, unf} === '0, "reset_state",
              {26'd0, busy, done, result, dbz, inv, ovf, unf}, 64'd0);
        check({busy64, done64, result64} === '0, "reset_state64", result64, 64'd0);
        reset_n = 1'b1;

        // flags order: {divide_by_zero, invalid, overflow, underflow}
        run_dir(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 1'b1);
        run_dir(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 1'b0);
        run_dir(32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 1'b0);
        run_dir(32'hBF800000, 32'h00000000, 32'hFF800000, 4'b1000, 1'b1);
        run_dir(32'h00000000, 32'h00000000, 32'h7FC00000, 4'b0100, 1'b0);
        run_dir(32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b0100, 1'b0);
        run_dir(32'hC0000000, 32'h7F800000, 32'h80000000, 4'b0000, 1'b0);
        run_dir(32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, 1'b0);
        run_dir(32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 1'b0);

        // start while busy is dropped; the next op after done is honoured
        run_op(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 1'b0, 1'b1, 1'b0);
        run_dir(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 1'b0);

        // reset in the middle of a divide
        @(negedge clk);
        a_in = 32'h40C00000; b_in = 32'h40000000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        check({busy, done, result} === '0, "reset_midop", {30'd0, busy, done, result}, 64'd0);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        run_dir(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 1'b0);

        for (int i = 0; i < 200; i++) begin
            run_ref(rand_fp(), rand_fp(), 1'b0, (i % 7) == 0);
        end

        // double-precision instance
        @(negedge clk);
        a64 = 64'h4018000000000000; b64 = 64'h4000000000000000; start64 = 1'b1;
        @(posedge clk); #1;
        start64 = 1'b0;
        edges = 0;
        while (!done64 && edges < 200) begin
            @(posedge clk); #1;
            edges++;
        end
        check(done64 && edges == 57, "latency64", 64'(edges), 64'd57);
        check(result64 === 64'h4008000000000000, "result64", result64, 64'h4008000000000000);
        check({dbz64, inv64, ovf64, unf64} === 4'b0000, "flags64", {60'd0, dbz64, inv64, ovf64, unf64}, 64'd0);

        repeat (5) @(posedge clk);
        #1;
        check(sb.size() == 0, "sb_drain", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
